matrix_mult_engine: RTL and testbench
=====================================

Name: matrix_mult_engine

Overview:
Parametrised successor of the team's single-configuration matrix multiplier. Computes C = A×B, or C += A×B, for runtime dimensions M×K by K×N up to MAX_DIM, using LANES parallel MAC rows, signed/unsigned operand mode, a start/busy/done handshake and dimension error reporting. Sits behind the accelerator register file: software writes operands and dimensions, pulses start, then polls done/err.

Parameters:
DATA_W, 32, operand element width
ACC_W, 32, result element width; accumulation wraps modulo 2^ACC_W
MAX_DIM, 4, maximum M, K, N; also the fixed row stride of all flat arrays
LANES, 2, rows processed in parallel per MAC cycle (1..MAX_DIM)
DIM_W, $clog2(MAX_DIM+1), width of dimension inputs

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request pulse, sampled in IDLE only
mode_signed  in  1  1 = operands two's complement
mode_accum  in  1  1 = C += A×B, 0 = C = A×B
dim_m  in  DIM_W  rows of A and C
dim_k  in  DIM_W  columns of A, rows of B
dim_n  in  DIM_W  columns of B and C
a_flat  in  DATA_W*MAX_DIM*MAX_DIM  A[r][k] at element index r*MAX_DIM+k
b_flat  in  DATA_W*MAX_DIM*MAX_DIM  B[k][c] at element index k*MAX_DIM+c
c_flat  out  ACC_W*MAX_DIM*MAX_DIM  C[r][c] at element index r*MAX_DIM+c
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky dimension error flag

Behaviour:
- Clock is clk. Reset is reset, synchronous and active-high; the polarity and synchronicity are fixed.
- Reset: state IDLE; busy=0, done=0, err=0; all c_flat elements 0; indices 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, LOAD, MAC, FIN.
- IDLE: if start=1 at edge t, latch dims and modes, clear err, and go to LOAD. While not in IDLE, start is ignored.
- LOAD (cycle t+1), with busy=1:
  - If any dim is 0 or greater than MAX_DIM: set err=1, leave C untouched, go to FIN.
  - Otherwise: if mode_accum=0, clear all MAX_DIM² C elements. Set i=j=k=0 and go to MAC.
- MAC, with busy=1: one cycle per (row group, column, k).
  - For each lane g with i+g < M: C[i+g][j] += ext(A[i+g][k]) × ext(B[k][j]).
  - Lanes with i+g ≥ M are masked and write nothing.
  - Loop order: k innermost, then j, then i += LANES.
  - The step with i+LANES ≥ M, j=N-1 and k=K-1 is the last MAC cycle; go to FIN.
- ext(): sign-extend when mode_signed=1, zero-extend otherwise. Product is 2*DATA_W bits, truncated or extended to ACC_W, and added modulo 2^ACC_W. No saturation.
- FIN: done=1 for exactly this cycle, busy=1, then IDLE with busy=0.
- Latency: done is high in cycle t+2+P, where P = ceil(M/LANES)·N·K. On error, done is high at t+2.
- a_flat and b_flat must be held stable while busy. The engine does not snapshot them.
- C elements outside M×N: zero after a non-accumulate run, unchanged after an accumulate run.
- err remains set until the next accepted start or reset.
- start in the same cycle as FIN is ignored. start is accepted on the first IDLE cycle.

Test Plan:
- Unsigned 2×2, LANES=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at t → C=[[19,22],[43,50]]; done pulse exactly at t+6; busy high t+1..t+6; other C elements 0.
- Signed 1×1, A=[[0xFFFFFFFF]] (-1), B=[[3]], mode_signed=1 → C[0][0]=0xFFFFFFFD. Same with mode_signed=0 → 0xFFFFFFFD (low 32 bits of 3·(2^32-1)).
- Accumulate: run the 2×2 case, then rerun with mode_accum=1 → C=[[38,44],[86,100]].
- Odd rows, M=3, K=2, N=1, LANES=2: A rows [1,1],[2,2],[3,3], B=[[1],[1]] → C column [2,4,6]. P=4, done at t+6. No write to row 3.
- Error: dim_k=0 → err=1 and done at t+2; C unchanged. The next valid start clears err.
- Reset asserted during MAC → next cycle busy=0, done=0, C all 0; a fresh start completes normally.

Source files
------------

// File: rtl/matrix_mult_engine.sv
// Runtime-dimensioned matrix multiply/accumulate engine, C = A*B or C += A*B.
// LANES rows of C advance together; one k step per MAC cycle.
module matrix_mult_engine #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 32,
    parameter int MAX_DIM = 4,
    parameter int LANES   = 2,
    parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode_signed,
    input  logic                              mode_accum,
    input  logic [DIM_W-1:0]                  dim_m,
    input  logic [DIM_W-1:0]                  dim_k,
    input  logic [DIM_W-1:0]                  dim_n,
    input  logic [DATA_W*MAX_DIM*MAX_DIM-1:0] a_flat,
    input  logic [DATA_W*MAX_DIM*MAX_DIM-1:0] b_flat,
    output logic [ACC_W*MAX_DIM*MAX_DIM-1:0]  c_flat,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int NE = MAX_DIM * MAX_DIM;
    localparam int IW = $clog2(2 * MAX_DIM + 1);
    localparam int PW = (ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        FIN
    } state_t;

    state_t state, state_n;

    logic [DIM_W-1:0] m_q, k_q, n_q;
    logic             sgn_q, acc_q;
    logic [IW-1:0]    i_q, j_q, kk_q;
    logic             err_q;
    logic [ACC_W-1:0] c_mem [NE];

    logic             dim_bad;
    logic             last_k, last_j, last_i;
    logic             lane_en [LANES];
    int               lane_ci [LANES];
    logic [ACC_W-1:0] prod    [LANES];

    assign dim_bad = (m_q == '0) || (k_q == '0) || (n_q == '0) ||
                     (m_q > DIM_W'(MAX_DIM)) || (k_q > DIM_W'(MAX_DIM)) ||
                     (n_q > DIM_W'(MAX_DIM));

    assign last_k = (kk_q + IW'(1)) == IW'(k_q);
    assign last_j = (j_q + IW'(1)) == IW'(n_q);
    assign last_i = (i_q + IW'(LANES)) >= IW'(m_q);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: state_n = dim_bad ? FIN : MAC;
            MAC:  if (last_i && last_j && last_k) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Per-lane operand fetch and product; masked lanes produce no write.
    always_comb begin
        for (int g = 0; g < LANES; g++) begin
            int               row;
            int               ai;
            int               bi;
            logic [DATA_W-1:0] a_el;
            logic [DATA_W-1:0] b_el;
            logic [PW-1:0]    ax;
            logic [PW-1:0]    bx;
            logic [PW-1:0]    full;
            row  = int'(i_q) + g;
            ai   = 0;
            bi   = 0;
            a_el = '0;
            b_el = '0;
            lane_en[g] = 1'b0;
            lane_ci[g] = 0;
            if (row < MAX_DIM && int'(kk_q) < MAX_DIM && int'(j_q) < MAX_DIM) begin
                ai   = row * MAX_DIM + int'(kk_q);
                bi   = int'(kk_q) * MAX_DIM + int'(j_q);
                a_el = a_flat[ai*DATA_W +: DATA_W];
                b_el = b_flat[bi*DATA_W +: DATA_W];
                lane_ci[g] = row * MAX_DIM + int'(j_q);
                lane_en[g] = (state == MAC) && (row < int'(m_q));
            end
            ax = {{(PW-DATA_W){sgn_q & a_el[DATA_W-1]}}, a_el};
            bx = {{(PW-DATA_W){sgn_q & b_el[DATA_W-1]}}, b_el};
            full = ax * bx;
            prod[g] = full[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q   <= '0;
            k_q   <= '0;
            n_q   <= '0;
            sgn_q <= 1'b0;
            acc_q <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
            kk_q  <= '0;
            err_q <= 1'b0;
            for (int e = 0; e < NE; e++) c_mem[e] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= dim_m;
                        k_q   <= dim_k;
                        n_q   <= dim_n;
                        sgn_q <= mode_signed;
                        acc_q <= mode_accum;
                        err_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (dim_bad) begin
                        err_q <= 1'b1;
                    end else begin
                        if (!acc_q) begin
                            for (int e = 0; e < NE; e++) c_mem[e] <= '0;
                        end
                        i_q  <= '0;
                        j_q  <= '0;
                        kk_q <= '0;
                    end
                end
                MAC: begin
                    for (int g = 0; g < LANES; g++) begin
                        if (lane_en[g]) begin
                            c_mem[lane_ci[g]] <= c_mem[lane_ci[g]] + prod[g];
                        end
                    end
                    // k innermost, then column, then the next row group.
                    if (last_k) begin
                        kk_q <= '0;
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= i_q + IW'(LANES);
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end else begin
                        kk_q <= kk_q + IW'(1);
                    end
                end
                FIN: begin
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar e = 0; e < NE; e++) begin : g_out
        assign c_flat[e*ACC_W +: ACC_W] = c_mem[e];
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign err  = err_q;

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Bench for matrix_mult_engine: reference model, expected-result queue,
// vector table plus directed sequences for latency, error, reset corners.
module tb_matrix_mult_engine;

    localparam int DATA_W  = 32;
    localparam int ACC_W   = 32;
    localparam int MAX_DIM = 4;
    localparam int LANES   = 2;
    localparam int DIM_W   = $clog2(MAX_DIM + 1);
    localparam int NE      = MAX_DIM * MAX_DIM;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    mode_signed;
    logic                    mode_accum;
    logic [DIM_W-1:0]        dim_m, dim_k, dim_n;
    logic [DATA_W*NE-1:0]    a_flat, b_flat;
    logic [ACC_W*NE-1:0]     c_flat;
    logic                    busy, done, err;

    matrix_mult_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_DIM(MAX_DIM),
        .LANES(LANES), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .mode_signed(mode_signed), .mode_accum(mode_accum),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c [NE];
        int          lat;
        bit          e;
    } exp_t;

    typedef struct {
        int m;
        int k;
        int n;
        bit sgn;
        bit acc;
        bit full;
    } vec_t;

    exp_t        sb [$];
    vec_t        tab [8];
    logic [31:0] a_m [NE];
    logic [31:0] b_m [NE];
    logic [31:0] c_model [NE];
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] cget(input int idx);
        return c_flat[idx*ACC_W +: ACC_W];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic model(input int m, input int k, input int n,
                         input bit sgn, input bit acc, output exp_t e);
        if (m < 1 || m > MAX_DIM || k < 1 || k > MAX_DIM ||
            n < 1 || n > MAX_DIM) begin
            e.e   = 1'b1;
            e.lat = 2;
        end else begin
            e.e   = 1'b0;
            e.lat = 2 + ((m + LANES - 1) / LANES) * n * k;
            if (!acc) begin
                for (int x = 0; x < NE; x++) c_model[x] = '0;
            end
            for (int r = 0; r < m; r++) begin
                for (int c = 0; c < n; c++) begin
                    logic [63:0] s;
                    s = {32'b0, c_model[r*MAX_DIM+c]};
                    for (int q = 0; q < k; q++) begin
                        logic [63:0] pa, pb;
                        pa = sgn ? {{32{a_m[r*MAX_DIM+q][31]}}, a_m[r*MAX_DIM+q]}
                                 : {32'b0, a_m[r*MAX_DIM+q]};
                        pb = sgn ? {{32{b_m[q*MAX_DIM+c][31]}}, b_m[q*MAX_DIM+c]}
                                 : {32'b0, b_m[q*MAX_DIM+c]};
                        s = s + pa * pb;
                    end
                    c_model[r*MAX_DIM+c] = s[31:0];
                end
            end
        end
        for (int x = 0; x < NE; x++) e.c[x] = c_model[x];
    endtask

    task automatic run(input int m, input int k, input int n,
                       input bit sgn, input bit acc, input bit poke,
                       input string nm);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   busy_ok;
        int   nbad;
        model(m, k, n, sgn, acc, e);
        sb.push_back(e);
        @(negedge clk);
        dim_m = DIM_W'(m);
        dim_k = DIM_W'(k);
        dim_n = DIM_W'(n);
        mode_signed = sgn;
        mode_accum = acc;
        for (int x = 0; x < NE; x++) begin
            a_flat[x*DATA_W +: DATA_W] = a_m[x];
            b_flat[x*DATA_W +: DATA_W] = b_m[x];
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        chk({nm, "_err_clr"}, {63'b0, err}, 64'd0);
        while (!done && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;
        if (!done) begin
            $display("FAIL %s_timeout got=%0d want=done", nm, cyc);
            bad++;
            total++;
        end
        if (poke) begin
            start = 1'b1;
            dim_m = DIM_W'(1);
            dim_k = DIM_W'(1);
            dim_n = DIM_W'(1);
        end
        got = sb.pop_front();
        chk({nm, "_lat"}, 64'(cyc), 64'(got.lat));
        chk({nm, "_busy"}, {63'b0, busy_ok}, 64'd1);
        chk({nm, "_errflag"}, {63'b0, err}, {63'b0, got.e});
        nbad = 0;
        for (int x = 0; x < NE; x++) begin
            if (cget(x) !== got.c[x]) begin
                if (nbad == 0)
                    $display("FAIL %s_c[%0d] got=%0h want=%0h",
                             nm, x, cget(x), got.c[x]);
                nbad++;
            end
        end
        total++;
        if (nbad != 0) bad++;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_idle"}, {62'b0, busy, done}, 64'd0);
    endtask

    task automatic fill(input bit full);
        for (int x = 0; x < NE; x++) begin
            a_m[x] = full ? $urandom : 32'($urandom_range(0, 15));
            b_m[x] = full ? $urandom : 32'($urandom_range(0, 15));
        end
    endtask

    task automatic set2x2;
        for (int x = 0; x < NE; x++) begin
            a_m[x] = 32'd9;
            b_m[x] = 32'd9;
        end
        a_m[0] = 1; a_m[1] = 2; a_m[4] = 3; a_m[5] = 4;
        b_m[0] = 5; b_m[1] = 6; b_m[4] = 7; b_m[5] = 8;
    endtask

    initial begin
        tab[0] = '{4, 4, 4, 1'b0, 1'b0, 1'b1};
        tab[1] = '{4, 4, 4, 1'b1, 1'b1, 1'b1};
        tab[2] = '{1, 3, 4, 1'b1, 1'b0, 1'b1};
        tab[3] = '{3, 1, 2, 1'b0, 1'b1, 1'b0};
        tab[4] = '{4, 2, 3, 1'b1, 1'b0, 1'b1};
        tab[5] = '{5, 2, 2, 1'b0, 1'b0, 1'b0};
        tab[6] = '{2, 2, 0, 1'b0, 1'b1, 1'b0};
        tab[7] = '{2, 3, 1, 1'b0, 1'b1, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        mode_signed = 1'b0;
        mode_accum = 1'b0;
        dim_m = '0;
        dim_k = '0;
        dim_n = '0;
        a_flat = '0;
        b_flat = '0;
        for (int x = 0; x < NE; x++) c_model[x] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_flags", {61'b0, busy, done, err}, 64'd0);
        chk("rst_c", {32'b0, c_flat[31:0] | c_flat[ACC_W*NE-1 -: 32]}, 64'd0);

        set2x2();
        run(2, 2, 2, 1'b0, 1'b0, 1'b0, "u2x2");
        chk("u2x2_c00", 64'(cget(0)), 64'd19);
        chk("u2x2_c01", 64'(cget(1)), 64'd22);
        chk("u2x2_c10", 64'(cget(4)), 64'd43);
        chk("u2x2_c11", 64'(cget(5)), 64'd50);
        chk("u2x2_c22", 64'(cget(10)), 64'd0);

        run(2, 2, 2, 1'b0, 1'b1, 1'b0, "acc2x2");
        chk("acc_c00", 64'(cget(0)), 64'd38);
        chk("acc_c11", 64'(cget(5)), 64'd100);

        a_m[0] = 32'hFFFF_FFFF;
        b_m[0] = 32'd3;
        run(1, 1, 1, 1'b1, 1'b0, 1'b0, "s1x1");
        chk("s1x1_c00", 64'(cget(0)), 64'hFFFF_FFFD);
        run(1, 1, 1, 1'b0, 1'b0, 1'b0, "u1x1");
        chk("u1x1_c00", 64'(cget(0)), 64'hFFFF_FFFD);

        for (int x = 0; x < NE; x++) begin
            a_m[x] = 32'd7;
            b_m[x] = 32'd7;
        end
        a_m[0] = 1; a_m[1] = 1; a_m[4] = 2; a_m[5] = 2;
        a_m[8] = 3; a_m[9] = 3;
        b_m[0] = 1; b_m[4] = 1;
        run(3, 2, 1, 1'b0, 1'b0, 1'b0, "odd");
        chk("odd_c0", 64'(cget(0)), 64'd2);
        chk("odd_c1", 64'(cget(4)), 64'd4);
        chk("odd_c2", 64'(cget(8)), 64'd6);
        chk("odd_row3", 64'(cget(12)), 64'd0);

        run(2, 0, 2, 1'b0, 1'b0, 1'b1, "errk0");
        chk("errk0_sticky", {63'b0, err}, 64'd1);
        set2x2();
        run(2, 2, 2, 1'b0, 1'b0, 1'b0, "after_err");
        chk("after_err_flag", {63'b0, err}, 64'd0);

        for (int t = 0; t < 8; t++) begin
            fill(tab[t].full);
            run(tab[t].m, tab[t].k, tab[t].n, tab[t].sgn, tab[t].acc,
                1'b0, $sformatf("tab%0d", t));
        end

        fill(1'b1);
        @(negedge clk);
        dim_m = DIM_W'(4);
        dim_k = DIM_W'(4);
        dim_n = DIM_W'(4);
        mode_accum = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_flags", {62'b0, busy, done}, 64'd0);
        begin
            int nz;
            nz = 0;
            for (int x = 0; x < NE; x++) if (cget(x) != 0) nz++;
            chk("mid_rst_c", 64'(nz), 64'd0);
        end
        reset = 1'b0;
        for (int x = 0; x < NE; x++) c_model[x] = '0;
        set2x2();
        run(2, 2, 2, 1'b0, 1'b1, 1'b0, "post_rst");
        chk("post_rst_c10", 64'(cget(4)), 64'd43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
